rom_read_arbiter: RTL

//   Shares one single-port synchronous ROM (1-cycle registered read, enable-gated)

---
 rtl/rom_read_arbiter_if.sv | 41 ++++
 rtl/rom_read_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter_if.sv
// rom_read_arbiter_if
//   Request/response bus between NUM_REQ client blocks and the shared ROM
//   read arbiter.
//   Signals:
//     req_valid  NUM_REQ             per-requester read request
//     req_addr   NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//     req_ready  NUM_REQ             one-hot accept from the arbiter
//     rsp_valid  NUM_REQ             one-hot, one-cycle response pulse
//     rsp_data   DATA_WIDTH          read data, held until the next response
//   Modports:
//     master  client side (drives requests, sinks responses)
//     slave   arbiter side
interface rom_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
//   Shares one single-port synchronous ROM (1-cycle registered read,
//   enable-gated) among NUM_REQ requesters. A three-state FSM
//   (IDLE -> READ -> WAIT) accepts one request, issues the ROM read, and
//   returns the data as a one-cycle one-hot response pulse, giving one read
//   every three cycles. This block is the only agent driving the ROM en/addr.
//   Ports:
//     clk       clock, all logic on posedge
//     rst       synchronous, active-high reset
//     bus       rom_read_arbiter_if.slave (req_valid/req_addr/req_ready,
//               rsp_valid/rsp_data)
//     rom_en    ROM read enable, high only in READ
//     rom_addr  ROM address, always the last accepted address
//     rom_data  ROM registered output
//   Configuration:
//     ROM_ARB_FIXED_PRIO_EN  defined: fixed priority, lowest valid index wins
//                            and the round-robin pointer is removed.
//                            undefined (default): round-robin arbitration.
module rom_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  rom_read_arbiter_if.slave     bus,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [IDX_W-1:0]      gnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [IDX_W-1:0]      winner;
  logic                  found;
  logic                  accept;
`ifndef ROM_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]      ptr_q;
`endif

  assign rom_addr = addr_q;

  // Winner selection. Loops run from the least to the most preferred
  // candidate so the last match, i.e. the preferred one, sticks.
  always_comb begin
    winner = '0;
    found  = 1'b0;
`ifdef ROM_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        winner = IDX_W'(i);
        found  = 1'b1;
      end
    end
`else
    // Offset k from the last grant: k=1 is the most preferred, k=NUM_REQ
    // (the last winner itself) the least.
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_valid[IDX_W'((int'(ptr_q) + k) % NUM_REQ)]) begin
        winner = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
        found  = 1'b1;
      end
    end
`endif
  end

  // Next-state and control outputs. Ready and the ROM enable are held low
  // while reset is asserted so nothing is accepted or read mid-reset.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    rom_en        = 1'b0;
    bus.req_ready = '0;
    case (state_q)
      IDLE: begin
        if (found && !rst) begin
          accept        = 1'b1;
          bus.req_ready = NUM_REQ'(1) << winner;
          state_d       = READ;
        end
      end
      READ: begin
        rom_en  = !rst;
        state_d = WAIT;
      end
      WAIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: the accepted address/grant are captured on accept; the ROM
  // output is valid during WAIT and is registered into the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      gnt_q         <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      ptr_q         <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      bus.rsp_valid <= '0;
      if (accept) begin
        addr_q <= bus.req_addr[int'(winner) * ADDR_WIDTH +: ADDR_WIDTH];
        gnt_q  <= winner;
`ifndef ROM_ARB_FIXED_PRIO_EN
        ptr_q  <= winner;
`endif
      end
      if (state_q == WAIT) begin
        bus.rsp_valid <= NUM_REQ'(1) << gnt_q;
        bus.rsp_data  <= rom_data;
      end
    end
  end

endmodule
